// File: rtl/ghost_dir_scheduler.sv
// Round-robin scheduler that lends one shared 5-bit LFSR to N ghost AIs for legal turn picks.
// Optional grant/fallback counters: define GHOST_DIR_SCHEDULER_STATS_EN.
module ghost_dir_scheduler #(
  parameter int N         = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] allow,
  input  logic [4:0]     rnd,
  output logic           rng_seed_load,
  output logic [N-1:0]   ack,
  output logic [1:0]     dir,
  output logic           no_move,
  output logic           busy
`ifdef GHOST_DIR_SCHEDULER_STATS_EN
  ,
  output logic [15:0]    stat_grants,
  output logic [15:0]    stat_fallbacks
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, SEED, DRAW, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] rr_reg, rr_next;
  logic [IDX_W-1:0] winner_reg, winner_next;
  logic [3:0]       mask_reg, mask_next;
  logic [3:0]       tries_reg, tries_next;
  logic             seeded_reg, seeded_next;
  logic [N-1:0]     ack_reg, ack_next;
  logic [1:0]       dir_reg, dir_next;
  logic             no_move_reg, no_move_next;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [1:0]       cand;
  logic             rnd_unused;

  assign cand       = rnd[1:0];
  assign rnd_unused = ^rnd[4:2];

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] m);
    logic [1:0] d;
    d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) d = 2'(i);
    end
    return d;
  endfunction

  // Scan starting at the round-robin pointer so the most recently served ghost goes last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && req[wrap_add(rr_reg, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_reg, k);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    winner_next  = winner_reg;
    mask_next    = mask_reg;
    tries_next   = tries_reg;
    seeded_next  = seeded_reg;
    ack_next     = ack_reg;
    dir_next     = dir_reg;
    no_move_next = no_move_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          winner_next = pick_idx;
          mask_next   = allow[{pick_idx, 2'b00} +: 4];
          tries_next  = 4'd0;
          state_next  = seeded_reg ? DRAW : SEED;
        end
      end
      SEED: begin
        seeded_next = 1'b1;
        state_next  = DRAW;
      end
      DRAW: begin
        if (!req[winner_reg]) begin
          state_next = IDLE;
        end else if (mask_reg == 4'b0000) begin
          dir_next              = 2'd0;
          no_move_next          = 1'b1;
          ack_next              = '0;
          ack_next[winner_reg]  = 1'b1;
          state_next            = DONE;
        end else if (mask_reg[cand]) begin
          dir_next              = cand;
          ack_next              = '0;
          ack_next[winner_reg]  = 1'b1;
          state_next            = DONE;
        end else if (tries_reg == LAST_TRY) begin
          dir_next              = lowest_dir(mask_reg);
          ack_next              = '0;
          ack_next[winner_reg]  = 1'b1;
          state_next            = DONE;
        end else begin
          tries_next = tries_reg + 4'd1;
        end
      end
      DONE: begin
        ack_next     = '0;
        dir_next     = 2'd0;
        no_move_next = 1'b0;
        rr_next      = wrap_add(winner_reg, 1);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      winner_reg  <= '0;
      mask_reg    <= 4'd0;
      tries_reg   <= 4'd0;
      seeded_reg  <= 1'b0;
      ack_reg     <= '0;
      dir_reg     <= 2'd0;
      no_move_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      winner_reg  <= winner_next;
      mask_reg    <= mask_next;
      tries_reg   <= tries_next;
      seeded_reg  <= seeded_next;
      ack_reg     <= ack_next;
      dir_reg     <= dir_next;
      no_move_reg <= no_move_next;
    end
  end

  assign rng_seed_load = (state_reg == SEED);
  assign busy          = (state_reg != IDLE);
  assign ack           = ack_reg;
  assign dir           = dir_reg;
  assign no_move       = no_move_reg;

`ifdef GHOST_DIR_SCHEDULER_STATS_EN
  logic        fallback_reg;
  logic [15:0] grants_reg, fallbacks_reg;

  // Remember how DRAW exited so the DONE cycle knows whether it was a fallback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fallback_reg  <= 1'b0;
      grants_reg    <= 16'd0;
      fallbacks_reg <= 16'd0;
    end else begin
      if (state_reg == DRAW)
        fallback_reg <= (mask_reg == 4'b0000) || (!mask_reg[cand] && (tries_reg == LAST_TRY));
      if (state_reg == DONE) begin
        if (grants_reg != 16'hFFFF) grants_reg <= grants_reg + 16'd1;
        if (fallback_reg && (fallbacks_reg != 16'hFFFF)) fallbacks_reg <= fallbacks_reg + 16'd1;
      end
    end
  end

  assign stat_grants    = grants_reg;
  assign stat_fallbacks = fallbacks_reg;
`endif

endmodule
